// File: rtl/piano_pkg.sv
// Shared types and constants for the piano key PWM scheduler.
package piano_pkg;

   localparam int         SLOT_W     = 7;
   localparam int         SLOTS      = 128;
   localparam logic [6:0] VEL_ALWAYS = 7'd127;

   typedef struct packed {
      logic [6:0] key;
      logic [6:0] vel;
   } cmd_t;

   typedef enum logic {
      IDLE,
      SWEEP
   } state_e;

endpackage

// File: rtl/piano_cmd_fifo.sv
// Command FIFO for the key scheduler. PIANO_SCHED_COALESCE_EN folds a push into
// a queued entry with the same key instead of appending.
module piano_cmd_fifo
   import piano_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  cmd_t push_cmd,
   input  logic pop,
   output cmd_t head,
   output logic full,
   output logic empty
);

   localparam int PTR_W = $clog2(DEPTH);

   cmd_t             mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             hit;
   logic             append;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

`ifdef PIANO_SCHED_COALESCE_EN
   logic [PTR_W-1:0] hit_idx;

   // The head being popped this cycle is already in flight and must not change.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!hit && (i < int'(count)) && !(pop && i == 0) &&
             mem[rd_ptr + PTR_W'(i)].key == push_cmd.key) begin
            hit     = 1'b1;
            hit_idx = rd_ptr + PTR_W'(i);
         end
      end
   end
`else
   assign hit = 1'b0;
`endif

   assign append = push && !hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
         if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
         if (append) wr_ptr <= wr_ptr + PTR_W'(1);
         case ({append, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (append) mem[wr_ptr] <= push_cmd;
`ifdef PIANO_SCHED_COALESCE_EN
      else if (push && hit) mem[hit_idx].vel <= push_cmd.vel;
`endif
   end

endmodule

// File: rtl/piano_key_sched.sv
// Key PWM scheduler: scans the pattern RAM onto key_out and rewrites one key column
// per queued command. Optional macro: PIANO_SCHED_COALESCE_EN.
module piano_key_sched
   import piano_pkg::*;
#(
   parameter int NUM_KEYS   = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [6:0]          cmd_key,
   input  logic [6:0]          cmd_vel,
   output logic                ram_r_en,
   output logic [SLOT_W-1:0]   ram_r_addr,
   input  logic [NUM_KEYS-1:0] ram_r_data,
   output logic                ram_w_en,
   output logic [SLOT_W-1:0]   ram_w_addr,
   output logic [NUM_KEYS-1:0] ram_w_data,
   output logic [NUM_KEYS-1:0] key_out,
   output logic                busy,
   output logic                done,
   output logic                err_key
);

   state_e              state_q;
   state_e              next_state;
   cmd_t                head;
   logic                full;
   logic                empty;
   logic                accept;
   logic                key_ok;
   logic                push;
   logic                pop;
   logic                sweep_write;
   logic [6:0]          key_q;
   logic [6:0]          vel_q;
   logic [7:0]          cnt_q;
   logic [SLOT_W-1:0]   slot;
   logic                slot_on;
   logic [NUM_KEYS-1:0] key_mask;
   logic [NUM_KEYS-1:0] new_word;

   assign cmd_ready = !full;
   assign accept    = cmd_valid && cmd_ready;
   assign key_ok    = ({1'b0, cmd_key} < 8'(NUM_KEYS));
   assign push      = accept && key_ok;
   assign ram_r_en  = 1'b1;
   assign busy      = (state_q == SWEEP);

   piano_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_cmd ('{key: cmd_key, vel: cmd_vel}),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= next_state;
   end

   // cnt_q counts computed slots; the 129th SWEEP cycle only drains the last write.
   always_comb begin
      next_state  = state_q;
      pop         = 1'b0;
      sweep_write = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               next_state = SWEEP;
            end
         end
         SWEEP: begin
            if (cnt_q == 8'd128) next_state  = IDLE;
            else                 sweep_write = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   // ram_r_data belongs to the address presented one cycle earlier.
   assign slot     = ram_r_addr - SLOT_W'(1);
   assign slot_on  = (vel_q == VEL_ALWAYS) || (slot < vel_q);
   assign key_mask = NUM_KEYS'(1) << key_q;
   assign new_word = slot_on ? (ram_r_data & ~key_mask) : (ram_r_data | key_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_r_addr <= '0;
         key_out    <= '1;
         key_q      <= '0;
         vel_q      <= '0;
         cnt_q      <= '0;
         ram_w_en   <= 1'b0;
         ram_w_addr <= '0;
         ram_w_data <= '0;
         done       <= 1'b0;
         err_key    <= 1'b0;
      end else begin
         ram_r_addr <= ram_r_addr + SLOT_W'(1);
         key_out    <= ram_r_data;
         err_key    <= accept && !key_ok;
         ram_w_en   <= sweep_write;
         done       <= sweep_write && (cnt_q == 8'd127);
         if (pop) begin
            key_q <= head.key;
            vel_q <= head.vel;
            cnt_q <= '0;
         end else if (sweep_write) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if (sweep_write) begin
            ram_w_addr <= slot;
            ram_w_data <= new_word;
         end
      end
   end

endmodule

// File: tb/tb_piano_key_sched.sv
// Directed bench for piano_key_sched with a behavioural 128 x NUM_KEYS pattern RAM.
module tb_piano_key_sched;

   localparam int NK = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [6:0]    cmd_key = '0;
   logic [6:0]    cmd_vel = '0;
   logic          cmd_ready;
   logic          ram_r_en;
   logic [6:0]    ram_r_addr;
   logic [NK-1:0] ram_r_data;
   logic          ram_w_en;
   logic [6:0]    ram_w_addr;
   logic [NK-1:0] ram_w_data;
   logic [NK-1:0] key_out;
   logic          busy;
   logic          done;
   logic          err_key;

   int checks = 0;
   int errors = 0;

   piano_key_sched #(.NUM_KEYS(NK), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_key    (cmd_key),
      .cmd_vel    (cmd_vel),
      .ram_r_en   (ram_r_en),
      .ram_r_addr (ram_r_addr),
      .ram_r_data (ram_r_data),
      .ram_w_en   (ram_w_en),
      .ram_w_addr (ram_w_addr),
      .ram_w_data (ram_w_data),
      .key_out    (key_out),
      .busy       (busy),
      .done       (done),
      .err_key    (err_key)
   );

   always #5 clk = ~clk;

   // Pattern RAM: 1-cycle read latency, filled with all ones while ram_fill is set.
   logic          ram_fill = 1'b1;
   logic [NK-1:0] mem [128];

   always @(posedge clk) begin
      if (ram_fill) begin
         for (int i = 0; i < 128; i++) mem[i] <= '1;
      end else if (ram_w_en) begin
         mem[ram_w_addr] <= ram_w_data;
      end
      if (ram_r_en) ram_r_data <= mem[ram_r_addr];
   end

   int cyc = 0;
   int n_writes = 0;
   int n_busy = 0;
   int n_done = 0;
   int n_done_nowrite = 0;
   int done_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_w_en) n_writes++;
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            done_cyc.push_back(cyc);
            if (!ram_w_en) n_done_nowrite++;
         end
      end
   end

   // Expected velocity per key; 0 is indistinguishable from a never-written key.
   int exp_vel [NK];

   function automatic int ram_mismatches();
      int bad = 0;
      for (int s = 0; s < 128; s++) begin
         logic [NK-1:0] w;
         w = '1;
         for (int k = 0; k < NK; k++)
            if (exp_vel[k] == 127 || s < exp_vel[k]) w[k] = 1'b0;
         if (mem[s] !== w) bad++;
      end
      return bad;
   endfunction

   task automatic send(input logic [6:0] k, input logic [6:0] v, output int acc_cyc);
      int waited = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_key   = k;
      cmd_vel   = v;
      while (!cmd_ready && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      acc_cyc = cyc;
      checks++;
      if (!cmd_ready) begin
         errors++;
         $display("FAIL send_accept: key %0d never accepted (cmd_ready=%b, want 1)", k, cmd_ready);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_dones(input int target, input int budget, input string name);
      int n = 0;
      while (n_done < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n_done < target) begin
         errors++;
         $display("FAIL %s: done pulses %0d, want %0d", name, n_done, target);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int bad_inc = 0;
      int prev;
      int w0;
      repeat (3) @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      checks++; if (ram_r_en !== 1'b1) begin errors++; $display("FAIL rst_r_en: got %b want 1", ram_r_en); end
      checks++; if (ram_r_addr !== 7'd0) begin errors++; $display("FAIL rst_r_addr: got %0d want 0", ram_r_addr); end
      checks++;
      if (ram_w_en !== 1'b0 || ram_w_addr !== 7'd0 || ram_w_data !== '0) begin
         errors++;
         $display("FAIL rst_write: got en=%b addr=%0d data=%h want 0/0/0", ram_w_en, ram_w_addr, ram_w_data);
      end
      checks++; if (key_out !== 12'hfff) begin errors++; $display("FAIL rst_key_out: got %h want fff", key_out); end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err_key !== 1'b0) begin
         errors++;
         $display("FAIL rst_flags: got busy=%b done=%b err=%b want 0", busy, done, err_key);
      end
      ram_fill = 1'b0;
      rst_n    = 1'b1;
      prev     = 0;
      w0       = n_writes;
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         if (int'(ram_r_addr) != ((prev + 1) % 128)) bad_inc++;
         prev = int'(ram_r_addr);
      end
      checks++; if (bad_inc != 0) begin errors++; $display("FAIL scan_addr: %0d bad steps, want 0", bad_inc); end
      checks++; if (n_writes != w0) begin errors++; $display("FAIL idle_writes: got %0d want 0", n_writes - w0); end
      checks++; if (key_out !== 12'hfff) begin errors++; $display("FAIL idle_key_out: got %h want fff", key_out); end
   endtask

   task automatic test_vel64();
      int acc, w0, d0, b0, low3, others;
      w0 = n_writes; d0 = n_done; b0 = n_busy;
      send(7'd3, 7'd64, acc);
      exp_vel[3] = 64;
      wait_dones(d0 + 1, 200, "vel64_done");
      checks++; if (n_writes - w0 != 128) begin errors++; $display("FAIL vel64_writes: got %0d want 128", n_writes - w0); end
      checks++; if (n_busy - b0 != 129) begin errors++; $display("FAIL vel64_busy: got %0d cycles want 129", n_busy - b0); end
      checks++;
      if (n_done > d0 && done_cyc[d0] - acc != 130) begin
         errors++;
         $display("FAIL vel64_latency: done %0d cycles after accept, want 130", done_cyc[d0] - acc);
      end
      checks++; if (n_done_nowrite != 0) begin errors++; $display("FAIL done_with_write: got %0d lone pulses want 0", n_done_nowrite); end
      checks++; if (ram_mismatches() != 0) begin errors++; $display("FAIL vel64_ram: %0d bad slots want 0", ram_mismatches()); end
      repeat (3) @(negedge clk);
      low3 = 0; others = 0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         if (key_out[3] === 1'b0) low3++;
         if ({key_out[NK-1:4], key_out[2:0]} !== '1) others++;
      end
      checks++; if (low3 != 64) begin errors++; $display("FAIL vel64_key_out: key3 low %0d cycles want 64", low3); end
      checks++; if (others != 0) begin errors++; $display("FAIL vel64_other_keys: %0d cycles disturbed want 0", others); end
      checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL vel64_once: got %0d pulses want 1", n_done - d0); end
   endtask

   task automatic test_full_and_off();
      int acc, d0;
      d0 = n_done;
      send(7'd5, 7'd127, acc);
      exp_vel[5] = 127;
      wait_dones(d0 + 1, 200, "key5_on_done");
      checks++; if (ram_mismatches() != 0) begin errors++; $display("FAIL key5_on_ram: %0d bad slots want 0", ram_mismatches()); end
      send(7'd5, 7'd0, acc);
      exp_vel[5] = 0;
      wait_dones(d0 + 2, 200, "key5_off_done");
      checks++; if (ram_mismatches() != 0) begin errors++; $display("FAIL key5_off_ram: %0d bad slots want 0", ram_mismatches()); end
   endtask

   task automatic test_err_key();
      int acc, d0, w0, busy_seen;
      d0 = n_done; w0 = n_writes;
      send(7'd12, 7'd50, acc);
      checks++; if (err_key !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", err_key); end
      @(posedge clk); #1;
      checks++; if (err_key !== 1'b0) begin errors++; $display("FAIL err_width: got %b want 0", err_key); end
      busy_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy) busy_seen++;
      end
      checks++; if (busy_seen != 0 || n_writes != w0) begin errors++; $display("FAIL err_no_sweep: busy %0d writes %0d want 0/0", busy_seen, n_writes - w0); end
      send(7'd9, 7'd127, acc);
      exp_vel[9] = 127;
      wait_dones(d0 + 1, 200, "after_err_done");
      repeat (140) @(negedge clk);
      checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL err_fifo_count: got %0d sweeps want 1", n_done - d0); end
      checks++; if (ram_mismatches() != 0) begin errors++; $display("FAIL after_err_ram: %0d bad slots want 0", ram_mismatches()); end
   endtask

   task automatic test_back_to_back();
      int acc, d0, n, short_gaps;
      d0 = n_done;
      send(7'd0, 7'd20, acc);
      n = 0;
      while (!busy && n < 10) begin @(negedge clk); n++; end
      send(7'd1, 7'd30, acc);
      send(7'd2, 7'd40, acc);
      send(7'd4, 7'd50, acc);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_3: got %b want 1", cmd_ready); end
      send(7'd8, 7'd100, acc);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: cmd_ready %b want 0", cmd_ready); end
      send(7'd1, 7'd110, acc);
      exp_vel[0] = 20; exp_vel[1] = 30; exp_vel[2] = 40; exp_vel[4] = 50;
      exp_vel[8] = 100; exp_vel[1] = 110;
      wait_dones(d0 + 6, 1000, "b2b_done");
      short_gaps = 0;
      for (int i = d0; i + 1 < n_done; i++)
         if (done_cyc[i + 1] - done_cyc[i] < 130) short_gaps++;
      checks++; if (short_gaps != 0) begin errors++; $display("FAIL b2b_spacing: %0d gaps under 130, want 0", short_gaps); end
      checks++; if (ram_mismatches() != 0) begin errors++; $display("FAIL b2b_ram: %0d bad slots want 0", ram_mismatches()); end
   endtask

`ifdef PIANO_SCHED_COALESCE_EN
   task automatic test_coalesce();
      int acc, d0, n;
      d0 = n_done;
      send(7'd6, 7'd5, acc);
      n = 0;
      while (!busy && n < 10) begin @(negedge clk); n++; end
      send(7'd2, 7'd10, acc);
      send(7'd2, 7'd90, acc);
      exp_vel[6] = 5; exp_vel[2] = 90;
      wait_dones(d0 + 2, 400, "coalesce_done");
      repeat (140) @(negedge clk);
      checks++; if (n_done != d0 + 2) begin errors++; $display("FAIL coalesce_count: got %0d sweeps want 2", n_done - d0); end
      checks++; if (ram_mismatches() != 0) begin errors++; $display("FAIL coalesce_ram: %0d bad slots want 0", ram_mismatches()); end
   endtask
`endif

   initial begin
      for (int k = 0; k < NK; k++) exp_vel[k] = 0;
      test_reset();
      test_vel64();
      test_full_and_off();
      test_err_key();
      test_back_to_back();
`ifdef PIANO_SCHED_COALESCE_EN
      test_coalesce();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
